lsu_align: RTL and testbench

- Load/store alignment stage between the pipeline MEM stage and one port of the dual-port byte-enable data RAM.
- Stores: converts byte address and RISC-V funct3 into a word address, write-byte-enable and lane-shifted write data.
- Loads: registers access info across the RAM's 1-cycle synchronous read, then extracts and sign/zero-extends the result.
- Optionally splits misaligned accesses into two word beats under an FSM that back-pressures the pipeline.

---
 rtl/lsu_align_if.sv | 26 ++
 rtl/lsu_align.sv | 81 ++++++++
 tb/tb_lsu_align.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if: pipeline request, RAM port and load response bundle for lsu_align.
interface lsu_align_if #(parameter int AWIDTH = 10);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [3:0]        mem_wbe;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, mem_en, mem_addr, mem_wbe, mem_d, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, mem_en, mem_addr, mem_wbe, mem_d, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load/store lane alignment for a byte-enable RAM port; define LSU_MISALIGN_EN to split misaligned accesses into two word beats.
module lsu_align #(parameter int AWIDTH = 10) (
    input logic       CLK,
    input logic       RST,
    lsu_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SPLIT, MERGE} state_t;
    state_t            state;
    logic [1:0]        off, off_r;
    logic [2:0]        f3_r;
    logic [3:0]        mask, wbe2_r;
    logic [7:0]        wbe_full;
    logic [63:0]       d_full;
    logic [AWIDTH-1:0] waddr, addr2_r;
    logic [31:0]       d2_r, low_q, rdata_r, sh, ext;
    logic              illegal, mis, bad, split, fire, err_r, rsp_valid_r, split_ld_r;
    logic              unused_addr;

    assign off         = bus.req_addr[1:0];
    assign waddr       = bus.req_addr[AWIDTH+1:2];
    assign unused_addr = ^bus.req_addr[31:AWIDTH+2];
    assign illegal     = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
    assign mis         = bus.req_funct3[1] ? (off != 2'd0) : (bus.req_funct3[0] && off == 2'd3);
`ifdef LSU_MISALIGN_EN
    assign bad   = illegal;
    assign split = mis && !illegal;
`else
    assign bad   = illegal || mis;
    assign split = 1'b0;
`endif
    assign fire     = bus.req_valid && bus.req_ready;
    assign mask     = bus.req_funct3[1] ? 4'hf : bus.req_funct3[0] ? 4'h3 : 4'h1;
    // Low halves are beat 1 (or the whole aligned access), high halves spill into beat 2.
    assign wbe_full = {4'b0, mask} << off;
    assign d_full   = {32'b0, bus.req_wdata} << {off, 3'b000};

    assign bus.req_ready = !RST && state == IDLE;
    assign bus.mem_en    = !RST && (state == SPLIT || fire);
    assign bus.mem_addr  = state == SPLIT ? addr2_r : waddr;
    assign bus.mem_wbe   = RST ? 4'b0 : state == SPLIT ? wbe2_r : (fire && bus.req_we && !bad) ? wbe_full[3:0] : 4'b0;
    assign bus.mem_d     = state == SPLIT ? d2_r : d_full[31:0];

    assign sh  = 32'((state == MERGE ? {bus.mem_q, low_q} : {32'b0, bus.mem_q}) >> {off_r, 3'b000});
    assign ext = f3_r[1] ? sh : f3_r[0] ? {{16{!f3_r[2] && sh[15]}}, sh[15:0]} : {{24{!f3_r[2] && sh[7]}}, sh[7:0]};
    // Read data arrives the cycle after mem_en, so the response is formed combinationally and held afterwards.
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = !rsp_valid_r ? rdata_r : err_r ? 32'b0 : ext;
    assign bus.rsp_err   = err_r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            if (rsp_valid_r) rdata_r <= bus.rsp_rdata;
            case (state)
                IDLE: if (fire) begin
                    off_r       <= off;
                    f3_r        <= bus.req_funct3;
                    err_r       <= bad;
                    rsp_valid_r <= !bus.req_we && !split;
                    split_ld_r  <= !bus.req_we;
                    addr2_r     <= waddr + AWIDTH'(1);
                    wbe2_r      <= bus.req_we ? wbe_full[7:4] : 4'b0;
                    d2_r        <= d_full[63:32];
                    if (split) state <= SPLIT;
                end
                SPLIT: begin
                    low_q       <= bus.mem_q;
                    rsp_valid_r <= split_ld_r;
                    state       <= split_ld_r ? MERGE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed scoreboard bench for lsu_align with a behavioural 1-cycle RAM.
module tb_lsu_align;
    localparam int AW = 10;
    typedef struct packed {logic v; logic e; logic [31:0] d;} rsp_t;
    typedef struct packed {logic [AW-1:0] a; logic [3:0] w; logic [31:0] d;} wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pre_en = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [31:0] pre_d = '0;
    logic [31:0] ram [0:2**AW-1];
    rsp_t rq[$];
    wr_t  wq[$];
    int tests = 0;
    int fails = 0;

    lsu_align_if #(.AWIDTH(AW)) bus();
    lsu_align #(.AWIDTH(AW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) ram[pre_a] <= pre_d;
        if (bus.mem_en) begin
            bus.mem_q <= ram[bus.mem_addr];
            for (int i = 0; i < 4; i++)
                if (bus.mem_wbe[i]) ram[bus.mem_addr][8*i+:8] <= bus.mem_d[8*i+:8];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t x;
        if (bus.rsp_valid || bus.rsp_err) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got v=%0b e=%0b d=%h expected none", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
            end else begin
                x = rq.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(x.v));
                chk("rsp_err", 32'(bus.rsp_err), 32'(x.e));
                if (x.v) chk("rsp_rdata", bus.rsp_rdata, x.d);
            end
        end
    end

    always @(negedge clk) begin
        wr_t y;
        if (bus.mem_en && bus.mem_wbe != 4'b0) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected: got a=%h w=%b d=%h expected none", bus.mem_addr, bus.mem_wbe, bus.mem_d);
            end else begin
                y = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(y.a));
                chk("wr_wbe", 32'(bus.mem_wbe), 32'(y.w));
                chk("wr_data", bus.mem_d, y.d);
            end
        end
    end

    task automatic exp_rsp(input logic v, input logic e, input logic [31:0] d);
        rq.push_back('{v, e, d});
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] d);
        wq.push_back('{a, w, d});
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        #1 chk("req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFF_FFFF; bus.mem_q = 32'h0;
        poke(0, 32'h1111_1111);
        poke(1, 32'h2222_2222);
        poke(2, 32'h3333_3333);
        poke(4, 32'h80FF_1234);
        @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_wbe", 32'(bus.mem_wbe), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.req_valid = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_idle_ready", 32'(bus.req_ready), 32'd1);

        exp_rsp(1, 0, 32'h1111_1111); issue(0, 3'b010, 32'h0, 0);
        exp_rsp(1, 0, 32'h2222_2222); issue(0, 3'b010, 32'h4, 0);
        exp_rsp(1, 0, 32'h3333_3333); issue(0, 3'b010, 32'h8, 0);
        idle(2);
        poke(1, 32'h80FF_FFFF);

        exp_wr(1, 4'b0100, 32'h00AB_0000); issue(1, 3'b000, 32'h6, 32'h0000_00AB);
        exp_rsp(1, 0, 32'hFFFF_FF80);      issue(0, 3'b000, 32'h7, 0);
        exp_rsp(1, 0, 32'h0000_0080);      issue(0, 3'b100, 32'h7, 0);
        idle(3);
        chk("rdata_hold", bus.rsp_rdata, 32'h0000_0080);
        exp_rsp(1, 0, 32'h80AB_FFFF);      issue(0, 3'b010, 32'h4, 0);
        exp_rsp(1, 0, 32'hFFFF_80FF);      issue(0, 3'b001, 32'h12, 0);
        exp_rsp(1, 0, 32'h0000_80FF);      issue(0, 3'b101, 32'h12, 0);
        exp_wr(0, 4'b1100, 32'hBEEF_0000); issue(1, 3'b001, 32'h2, 32'h1234_BEEF);
        exp_wr(2, 4'b1111, 32'hCAFE_F00D); issue(1, 3'b010, 32'h8, 32'hCAFE_F00D);
        exp_rsp(1, 0, 32'hCAFE_F00D);      issue(0, 3'b010, 32'h8, 0);

        exp_rsp(0, 1, 0); issue(1, 3'b011, 32'h0, 32'hFFFF_FFFF);
        chk("wbe_illegal", 32'(bus.mem_wbe), 32'd0);
        exp_rsp(0, 1, 0); issue(1, 3'b100, 32'h0, 32'hFFFF_FFFF);
        exp_rsp(1, 1, 0); issue(0, 3'b110, 32'h4, 0);
`ifndef LSU_MISALIGN_EN
        exp_rsp(1, 1, 0); issue(0, 3'b010, 32'h2, 0);
        exp_rsp(0, 1, 0); issue(1, 3'b001, 32'h3, 32'hFFFF_FFFF);
        chk("wbe_misaligned", 32'(bus.mem_wbe), 32'd0);
        idle(3);
`else
        idle(2);
        poke(1, 32'hDDCC_BBAA);
        poke(2, 32'h4433_2211);
        exp_rsp(1, 0, 32'h2211_DDCC); issue(0, 3'b010, 32'h6, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1;
        chk("split_ready", 32'(bus.req_ready), 32'd0);
        chk("split_addr", 32'(bus.mem_addr), 32'd2);
        chk("split_en", 32'(bus.mem_en), 32'd1);
        idle(3);
        exp_rsp(1, 0, 32'hFFFF_AABE); issue(0, 3'b001, 32'h3, 0);
        idle(4);
        exp_wr(AW'(2**AW-1), 4'b1000, 32'hD400_0000);
        exp_wr(0, 4'b0111, 32'h00A1_B2C3);
        issue(1, 3'b010, 32'h0000_0FFF, 32'hA1B2_C3D4);
        idle(3);
        exp_wr(AW'(2**AW-1), 4'b1000, 32'hD400_0000);
        issue(1, 3'b010, 32'h0000_0FFF, 32'hA1B2_C3D4);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_split_en", 32'(bus.mem_en), 32'd0);
        chk("rst_split_wbe", 32'(bus.mem_wbe), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("rst_split_idle", 32'(bus.req_ready), 32'd1);
        exp_rsp(1, 0, 32'hBEA1_B2C3); issue(0, 3'b010, 32'h0, 0);
        idle(3);
`endif
        idle(4);
        chk("rsp_queue_left", rq.size(), 32'd0);
        chk("wr_queue_left", wq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
